// File: rtl/gate_unit_arbiter.sv
// Two-requester round-robin front end for a single NOR-built gate unit.
// Each granted request is evaluated once and held until the consumer takes it.

// NOR-only realisation of the basic two-input gates.
// Latency: combinational.
// Backpressure: none; outputs follow inputs.
module logic_gates_using_nor (
  input  logic a,
  input  logic b,
  output logic y_and,
  output logic y_or,
  output logic y_not_a,
  output logic y_nand,
  output logic y_xor,
  output logic y_xnor
);
  logic n_ab;
  logic n_a;
  logic n_b;
  logic t_xor;

  assign n_ab    = ~(a | b);
  assign n_a     = ~(a | a);
  assign n_b     = ~(b | b);
  assign y_or    = ~(n_ab | n_ab);
  assign y_and   = ~(n_a | n_b);
  assign y_not_a = n_a;
  assign y_nand  = ~(y_and | y_and);
  // a^b is high exactly when neither "both low" nor "both high" holds.
  assign t_xor   = ~(y_and | n_ab);
  assign y_xor   = t_xor;
  assign y_xnor  = ~(t_xor | t_xor);
endmodule

// Round-robin arbiter feeding one gate unit through an IDLE/EVAL/DONE sequence.
// Latency: grant on the sampling edge, result valid after the next edge.
// Backpressure: result held in DONE until out_ready; new requests ignored while busy.
module gate_unit_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic             a0,
  input  logic             b0,
  input  logic [2:0]       op0,
  input  logic             a1,
  input  logic             b1,
  input  logic [2:0]       op1,
  output logic [1:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             out_id,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t     state;
  logic       ptr;
  logic       win;
  logic       a_q;
  logic       b_q;
  logic [2:0] op_q;
  logic       id_q;
  logic       g_and, g_or, g_not_a, g_nand, g_xor, g_xnor;
  logic       gate_res;
  logic       gate_err;

  logic_gates_using_nor u_gates (
    .a      (a_q),
    .b      (b_q),
    .y_and  (g_and),
    .y_or   (g_or),
    .y_not_a(g_not_a),
    .y_nand (g_nand),
    .y_xor  (g_xor),
    .y_xnor (g_xnor)
  );

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    win = ptr;
    if (req == 2'b01) win = 1'b0;
    else if (req == 2'b10) win = 1'b1;
  end

  always_comb begin
    gate_res = 1'b0;
    gate_err = 1'b0;
    case (op_q)
      3'd0:    gate_res = g_and;
      3'd1:    gate_res = g_or;
      3'd2:    gate_res = g_not_a;
      3'd3:    gate_res = g_nand;
      3'd4:    gate_res = g_xor;
      3'd5:    gate_res = g_xnor;
      default: gate_err = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      out_valid  <= 1'b0;
      result     <= 1'b0;
      out_id     <= 1'b0;
      out_err    <= 1'b0;
      done_count <= '0;
      ptr        <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      op_q       <= 3'd0;
      id_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            id_q  <= win;
            a_q   <= win ? a1 : a0;
            b_q   <= win ? b1 : b0;
            op_q  <= win ? op1 : op0;
            gnt   <= win ? 2'b10 : 2'b01;
            ptr   <= ~win;
            state <= EVAL;
          end
        end
        EVAL: begin
          gnt       <= 2'b00;
          result    <= gate_res;
          out_err   <= gate_err;
          out_id    <= id_q;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            done_count <= done_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter: reset, single op, contention,
// backpressure, illegal opcode, reset mid-hold, truth tables and counter wrap.
module tb_gate_unit_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic       a0 = 1'b0, b0 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic [2:0] op0 = 3'd0, op1 = 3'd0;
  logic [1:0] gnt;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       result, out_id, out_err, busy;
  logic [7:0] done_count;

  int checks = 0;
  int passed = 0;

  gate_unit_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .op0(op0),
    .a1(a1), .b1(b1), .op1(op1),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_id(out_id), .out_err(out_err),
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic model(input int op, input logic a, input logic b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~a;
      3: return ~(a & b);
      4: return a ^ b;
      5: return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    checks++; if (result !== 1'b0 || out_id !== 1'b0 || out_err !== 1'b0) $display("FAIL reset_outs: got %b%b%b want 000", result, out_id, out_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", done_count); else passed++;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || gnt !== 2'b00) $display("FAIL idle_no_req: got busy %b gnt %b want 0 00", busy, gnt); else passed++;
  endtask

  task automatic test_single();
    req = 2'b01; a0 = 1'b1; b0 = 1'b0; op0 = 3'd4;
    tick();
    checks++; if (gnt !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt); else passed++;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL single_eval: got busy %b valid %b want 1 0", busy, out_valid); else passed++;
    // Operands change after the grant and ready arrives early: both must be ignored.
    req = 2'b00; a0 = 1'b0; op0 = 3'd0; out_ready = 1'b1;
    tick();
    checks++; if (gnt !== 2'b00) $display("FAIL single_gnt_pulse: got %b want 00", gnt); else passed++;
    checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
    checks++; if (result !== 1'b1 || out_id !== 1'b0 || out_err !== 1'b0) $display("FAIL single_result: got r%b id%b e%b want r1 id0 e0", result, out_id, out_err); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0 || done_count !== 8'd1) $display("FAIL single_accept: got valid %b count %0d want 0 1", out_valid, done_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: got busy %b want 0", busy); else passed++;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    apply_reset();
    req = 2'b11; out_ready = 1'b1;
    a0 = 1'b1; b0 = 1'b1; op0 = 3'd0; a1 = 1'b0; b1 = 1'b0; op1 = 3'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (gnt !== exp_g[k]) $display("FAIL contention_gnt%0d: got %b want %b", k, gnt, exp_g[k]); else passed++;
      tick();
      checks++; if (out_id !== exp_g[k][1] || result !== ~exp_g[k][1]) $display("FAIL contention_res%0d: got id %b r %b want id %b r %b", k, out_id, result, exp_g[k][1], ~exp_g[k][1]); else passed++;
      tick();
      checks++; if (gnt !== 2'b00) $display("FAIL contention_spacing%0d: got %b want 00", k, gnt); else passed++;
    end
    req = 2'b00;
    checks++; if (done_count !== 8'd3) $display("FAIL contention_count: got %0d want 3", done_count); else passed++;
  endtask

  task automatic test_backpressure();
    // Pointer now favours requester 1 (last grant went to 0).
    req = 2'b01; a0 = 1'b1; b0 = 1'b1; op0 = 3'd0; out_ready = 1'b0;
    a1 = 1'b0; b1 = 1'b0; op1 = 3'd3;
    tick();
    checks++; if (gnt !== 2'b01) $display("FAIL bp_gnt: got %b want 01", gnt); else passed++;
    req = 2'b11;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || result !== 1'b1) $display("FAIL bp_hold%0d: got valid %b r %b want 1 1", k, out_valid, result); else passed++;
      checks++; if (busy !== 1'b1 || gnt !== 2'b00) $display("FAIL bp_busy%0d: got busy %b gnt %b want 1 00", k, busy, gnt); else passed++;
      checks++; if (done_count !== 8'd3) $display("FAIL bp_count%0d: got %0d want 3", k, done_count); else passed++;
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || done_count !== 8'd4) $display("FAIL bp_accept: got valid %b count %0d want 0 4", out_valid, done_count); else passed++;
    tick();
    checks++; if (gnt !== 2'b10) $display("FAIL bp_rearb: got %b want 10", gnt); else passed++;
    req = 2'b00;
    tick();
    checks++; if (result !== 1'b1 || out_id !== 1'b1) $display("FAIL bp_nand: got r %b id %b want 1 1", result, out_id); else passed++;
    tick();
    checks++; if (done_count !== 8'd5) $display("FAIL bp_count_end: got %0d want 5", done_count); else passed++;
  endtask

  task automatic test_illegal();
    req = 2'b10; a1 = 1'b1; b1 = 1'b1; op1 = 3'd7; out_ready = 1'b1;
    tick();
    checks++; if (gnt !== 2'b10) $display("FAIL illegal_gnt: got %b want 10", gnt); else passed++;
    req = 2'b00;
    tick();
    checks++; if (result !== 1'b0 || out_err !== 1'b1 || out_id !== 1'b1) $display("FAIL illegal_out: got r%b e%b id%b want r0 e1 id1", result, out_err, out_id); else passed++;
    tick();
    checks++; if (done_count !== 8'd6 || out_valid !== 1'b0) $display("FAIL illegal_count: got %0d valid %b want 6 0", done_count, out_valid); else passed++;
  endtask

  task automatic test_reset_done();
    req = 2'b01; a0 = 1'b1; b0 = 1'b0; op0 = 3'd1; out_ready = 1'b0;
    tick();
    req = 2'b00;
    tick();
    tick();
    checks++; if (out_valid !== 1'b1 || result !== 1'b1) $display("FAIL rstdone_pre: got valid %b r %b want 1 1", out_valid, result); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || result !== 1'b0) $display("FAIL rstdone_async: got valid %b r %b want 0 0", out_valid, result); else passed++;
    checks++; if (done_count !== 8'd0 || busy !== 1'b0) $display("FAIL rstdone_state: got count %0d busy %b want 0 0", done_count, busy); else passed++;
    rst = 1'b0;
    req = 2'b10; a1 = 1'b0; b1 = 1'b1; op1 = 3'd2;
    tick();
    checks++; if (gnt !== 2'b10) $display("FAIL rstdone_gnt: got %b want 10", gnt); else passed++;
    req = 2'b00; out_ready = 1'b1;
    tick();
    checks++; if (result !== 1'b1 || out_id !== 1'b1) $display("FAIL rstdone_res: got r %b id %b want 1 1", result, out_id); else passed++;
    tick();
    checks++; if (done_count !== 8'd1) $display("FAIL rstdone_count: got %0d want 1", done_count); else passed++;
  endtask

  task automatic test_truth_wrap();
    int op;
    logic a, b;
    apply_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      op = (n < 24) ? n / 4 : n % 8;
      a = ((n % 4) >= 2);
      b = ((n % 2) == 1);
      a0 = a; b0 = b; op0 = 3'(op);
      a1 = a; b1 = b; op1 = 3'(op);
      req = (n % 2 == 1) ? 2'b10 : 2'b01;
      tick();
      req = 2'b00;
      tick();
      if (n < 24) begin
        checks++; if (result !== model(op, a, b) || out_err !== 1'b0) $display("FAIL truth op%0d a%b b%b: got r%b e%b want r%b e0", op, a, b, result, out_err, model(op, a, b)); else passed++;
      end else if (op >= 6) begin
        checks++; if (result !== 1'b0 || out_err !== 1'b1) $display("FAIL wrap_illegal n%0d: got r%b e%b want r0 e1", n, result, out_err); else passed++;
      end
      tick();
      if (n == 254) begin
        checks++; if (done_count !== 8'd255) $display("FAIL wrap_top: got %0d want 255", done_count); else passed++;
      end
    end
    checks++; if (done_count !== 8'd0) $display("FAIL wrap_zero: got %0d want 0", done_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_done();
    test_truth_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
